// File: rtl/riscv_core_mul_div_issue.sv
// -----------------------------------------------------------------------------
// riscv_core_mul_div_issue
//
// Requester side of the M-extension unit interface. An op from execute is
// accepted in IDLE, its operands are registered and presented to the mul/div
// unit, and the pipeline is stalled until the result is back. Multiplies
// complete one cycle after issue. Divides complete when the unit raises done,
// or are aborted by a watchdog. A completed op produces a one-cycle writeback
// strobe.
//
// Ports
//   i_mdi_clk, i_mdi_rst      clock, synchronous active-high reset
//   i_mdi_valid               execute holds a mul/div op
//   i_mdi_srcA/srcB           operands (XLEN)
//   i_mdi_control[3:0]        [2]=1 divide/rem, [2]=0 multiply; [1:0] op select
//   i_mdi_isword              *W variant (result sign-extended from bit 31)
//   i_mdi_rd                  destination register
//   i_mdi_flush               kill the in-flight op
//   o_mdi_unit_*              request enable and registered operands to the unit
//   i_mdi_unit_done           divide complete (looked at only while dividing)
//   i_mdi_unit_result         unit result
//   o_mdi_stall               hold IF/ID/EX
//   o_mdi_wb_valid/rd/data    one-cycle writeback; rd/data hold between strobes
//   o_mdi_err                 one-cycle divide-timeout pulse
// -----------------------------------------------------------------------------
module riscv_core_mul_div_issue #(
  parameter int XLEN        = 64,
  parameter int DIV_TIMEOUT = 127
) (
  input  logic            i_mdi_clk,
  input  logic            i_mdi_rst,
  input  logic            i_mdi_valid,
  input  logic [XLEN-1:0] i_mdi_srcA,
  input  logic [XLEN-1:0] i_mdi_srcB,
  input  logic [3:0]      i_mdi_control,
  input  logic            i_mdi_isword,
  input  logic [4:0]      i_mdi_rd,
  input  logic            i_mdi_flush,
  output logic            o_mdi_unit_en,
  output logic [XLEN-1:0] o_mdi_unit_srcA,
  output logic [XLEN-1:0] o_mdi_unit_srcB,
  output logic [3:0]      o_mdi_unit_control,
  output logic            o_mdi_unit_isword,
  input  logic            i_mdi_unit_done,
  input  logic [XLEN-1:0] i_mdi_unit_result,
  output logic            o_mdi_stall,
  output logic            o_mdi_wb_valid,
  output logic [4:0]      o_mdi_wb_rd,
  output logic [XLEN-1:0] o_mdi_wb_data,
  output logic            o_mdi_err
);

  localparam int CNT_W = $clog2(DIV_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_WB   = 2'd3
  } state_t;

  state_t            state_q,   state_d;
  logic [XLEN-1:0]   src_a_q,   src_a_d;
  logic [XLEN-1:0]   src_b_q,   src_b_d;
  logic [3:0]        ctrl_q,    ctrl_d;
  logic              isword_q,  isword_d;
  logic [4:0]        rd_q,      rd_d;
  logic [CNT_W-1:0]  cnt_q,     cnt_d;
  logic [XLEN-1:0]   wb_data_q, wb_data_d;
  logic [4:0]        wb_rd_q,   wb_rd_d;
  logic              err_q,     err_d;
  logic              accept;

  // Word ops always return a sign-extended 32-bit value, whatever the unit
  // put in the upper half.
  function automatic logic [XLEN-1:0] word_ext(input logic [XLEN-1:0] res,
                                               input logic            isword);
    word_ext = isword ? {{(XLEN-32){res[31]}}, res[31:0]} : res;
  endfunction

  assign accept = (state_q == S_IDLE) && i_mdi_valid && !i_mdi_flush;

  always_comb begin
    state_d   = state_q;
    src_a_d   = src_a_q;
    src_b_d   = src_b_q;
    ctrl_d    = ctrl_q;
    isword_d  = isword_q;
    rd_d      = rd_q;
    cnt_d     = cnt_q;
    wb_data_d = wb_data_q;
    wb_rd_d   = wb_rd_q;
    err_d     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          src_a_d  = i_mdi_srcA;
          src_b_d  = i_mdi_srcB;
          ctrl_d   = i_mdi_control;
          isword_d = i_mdi_isword;
          rd_d     = i_mdi_rd;
          cnt_d    = '0;
          state_d  = i_mdi_control[2] ? S_DIV : S_MUL;
        end
      end
      S_MUL: begin
        if (i_mdi_flush) begin
          state_d = S_IDLE;
        end else begin
          wb_data_d = word_ext(i_mdi_unit_result, isword_q);
          wb_rd_d   = rd_q;
          state_d   = S_WB;
        end
      end
      S_DIV: begin
        cnt_d = cnt_q + CNT_W'(1);
        // Flush beats a same-cycle done; done beats the watchdog. cnt_q is
        // the number of DIV cycles already spent, so the abort fires at the
        // end of the DIV_TIMEOUT-th one.
        if (i_mdi_flush) begin
          state_d = S_IDLE;
        end else if (i_mdi_unit_done) begin
          wb_data_d = word_ext(i_mdi_unit_result, isword_q);
          wb_rd_d   = rd_q;
          state_d   = S_WB;
        end else if (cnt_q == CNT_W'(DIV_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_WB: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_mdi_clk) begin
    if (i_mdi_rst) begin
      state_q   <= S_IDLE;
      src_a_q   <= '0;
      src_b_q   <= '0;
      ctrl_q    <= '0;
      isword_q  <= 1'b0;
      rd_q      <= '0;
      cnt_q     <= '0;
      wb_data_q <= '0;
      wb_rd_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_a_q   <= src_a_d;
      src_b_q   <= src_b_d;
      ctrl_q    <= ctrl_d;
      isword_q  <= isword_d;
      rd_q      <= rd_d;
      cnt_q     <= cnt_d;
      wb_data_q <= wb_data_d;
      wb_rd_q   <= wb_rd_d;
      err_q     <= err_d;
    end
  end

  // Enable is high only while an op is outstanding, so every op gives the
  // unit exactly one rising edge. Stall drops in WB so the EX op retires.
  assign o_mdi_unit_en      = (state_q == S_MUL) || (state_q == S_DIV);
  assign o_mdi_stall        = accept || (state_q == S_MUL) || (state_q == S_DIV);
  assign o_mdi_unit_srcA    = src_a_q;
  assign o_mdi_unit_srcB    = src_b_q;
  assign o_mdi_unit_control = ctrl_q;
  assign o_mdi_unit_isword  = isword_q;
  assign o_mdi_wb_valid     = (state_q == S_WB);
  assign o_mdi_wb_rd        = wb_rd_q;
  assign o_mdi_wb_data      = wb_data_q;
  assign o_mdi_err          = err_q;

endmodule
